// File: rtl/arbitro_ulauc_pkg.sv
// Shared definitions for the two-requester mantissa ALU arbiter.
package arbitro_ulauc_pkg;

   localparam int unsigned MANT_W      = 24;
   localparam int unsigned RES_W       = 28;
   localparam int unsigned TIMEOUT_DEF = 80;

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      DISPARA = 2'd1,
      AGUARDA = 2'd2,
      ENTREGA = 2'd3
   } estado_t;

endpackage

// File: rtl/arbitro_ulauc.sv
// Arbiter sharing one mantissa ALU between two requesters, with a round-robin
// tie break, a start pulse, first-cycle finish blanking and a timeout abort.
module arbitro_ulauc
   import arbitro_ulauc_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [MANT_W-1:0] req0_a,
   input  logic [MANT_W-1:0] req0_b,
   input  logic              req0_mult,
   output logic              req0_done,
   output logic [RES_W-1:0]  req0_dout,
   output logic              req0_erro,

   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [MANT_W-1:0] req1_a,
   input  logic [MANT_W-1:0] req1_b,
   input  logic              req1_mult,
   output logic              req1_done,
   output logic [RES_W-1:0]  req1_dout,
   output logic              req1_erro,

   output logic [MANT_W-1:0] ula_a,
   output logic [MANT_W-1:0] ula_b,
   output logic              ula_multiplica,
   output logic              ula_start,
   input  logic              ula_finish,
   input  logic [RES_W-1:0]  ula_dout,

   output logic              ocupado
);

   localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   estado_t           estado;
   estado_t           prox;
   logic              prio;
   logic              gnt;
   logic              win;
   logic              aceita;
   logic [MANT_W-1:0] a_q;
   logic [MANT_W-1:0] b_q;
   logic              mult_q;
   logic [CNT_W-1:0]  cnt;
   logic              fin_ok;
   logic              tmo;
   logic [RES_W-1:0]  dout0_q;
   logic [RES_W-1:0]  dout1_q;
   logic              erro0_q;
   logic              erro1_q;

   // cnt == 0 marks the first AGUARDA cycle, where a finish left over from the previous op is ignored
   assign fin_ok = ula_finish && (cnt != '0);
   assign tmo    = (cnt == CNT_W'(TIMEOUT - 1));

   // Winner selection, ready strobes and next-state logic
   always_comb begin
      prox       = estado;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      aceita     = 1'b0;
      win        = prio;
      if (req0_valid && !req1_valid) begin
         win = 1'b0;
      end else if (req1_valid && !req0_valid) begin
         win = 1'b1;
      end
      case (estado)
         OCIOSO: begin
            if (!reset && (req0_valid || req1_valid)) begin
               req0_ready = !win;
               req1_ready = win;
               aceita     = 1'b1;
               prox       = DISPARA;
            end
         end
         DISPARA: prox = AGUARDA;
         AGUARDA: begin
            if (fin_ok || tmo) begin
               prox = ENTREGA;
            end
         end
         ENTREGA: prox = OCIOSO;
         default: prox = OCIOSO;
      endcase
   end

   // State register, operand latch, wait counter and per-requester result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         estado  <= OCIOSO;
         prio    <= 1'b0;
         gnt     <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         mult_q  <= 1'b0;
         cnt     <= '0;
         dout0_q <= '0;
         dout1_q <= '0;
         erro0_q <= 1'b0;
         erro1_q <= 1'b0;
      end else begin
         estado <= prox;
         case (estado)
            OCIOSO: begin
               if (aceita) begin
                  gnt    <= win;
                  a_q    <= win ? req1_a : req0_a;
                  b_q    <= win ? req1_b : req0_b;
                  mult_q <= win ? req1_mult : req0_mult;
                  prio   <= !win;
               end
            end
            DISPARA: cnt <= '0;
            AGUARDA: begin
               cnt <= cnt + CNT_W'(1);
               // finish takes precedence over a timeout in the same cycle
               if (fin_ok) begin
                  if (gnt) begin
                     dout1_q <= ula_dout;
                     erro1_q <= 1'b0;
                  end else begin
                     dout0_q <= ula_dout;
                     erro0_q <= 1'b0;
                  end
               end else if (tmo) begin
                  if (gnt) begin
                     dout1_q <= '0;
                     erro1_q <= 1'b1;
                  end else begin
                     dout0_q <= '0;
                     erro0_q <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign ula_a          = a_q;
   assign ula_b          = b_q;
   assign ula_multiplica = mult_q;
   assign ula_start      = (estado == DISPARA);
   assign ocupado        = (estado != OCIOSO);
   assign req0_done      = (estado == ENTREGA) && !gnt;
   assign req1_done      = (estado == ENTREGA) && gnt;
   assign req0_dout      = dout0_q;
   assign req1_dout      = dout1_q;
   assign req0_erro      = erro0_q;
   assign req1_erro      = erro1_q;

endmodule

// File: tb/tb_arbitro_ulauc.sv
// Scoreboard bench for arbitro_ulauc with a behavioural stub ALU.
module tb_arbitro_ulauc;
   import arbitro_ulauc_pkg::*;

   localparam int unsigned TO = 80;

   logic              clk = 1'b0;
   logic              reset;
   logic              req0_valid, req0_ready, req0_mult, req0_done, req0_erro;
   logic              req1_valid, req1_ready, req1_mult, req1_done, req1_erro;
   logic [23:0]       req0_a, req0_b, req1_a, req1_b;
   logic [27:0]       req0_dout, req1_dout;
   logic [23:0]       ula_a, ula_b;
   logic              ula_multiplica, ula_start, ula_finish, ocupado;
   logic [27:0]       ula_dout;

   always #5 clk = ~clk;

   arbitro_ulauc #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req0_mult(req0_mult), .req0_done(req0_done), .req0_dout(req0_dout), .req0_erro(req0_erro),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .req1_mult(req1_mult), .req1_done(req1_done), .req1_dout(req1_dout), .req1_erro(req1_erro),
      .ula_a(ula_a), .ula_b(ula_b), .ula_multiplica(ula_multiplica), .ula_start(ula_start),
      .ula_finish(ula_finish), .ula_dout(ula_dout), .ocupado(ocupado)
   );

   typedef struct {
      logic        id;
      logic [27:0] dout;
      logic        erro;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          starts = 0;
   int          last_start = 0;
   int          dones = 0;
   int          stub_mode = 0;
   logic [27:0] sh0_dout = '0, sh1_dout = '0;
   logic        sh0_erro = 1'b0, sh1_erro = 1'b0;
   logic        chk_ocup = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Stub ALU: j counts cycles since the start pulse (j = 0 in the start cycle)
   initial begin
      int j;
      j = 1000;
      ula_finish = 1'b0;
      ula_dout   = '0;
      forever begin
         @(negedge clk);
         if (ula_start) begin
            j = 0;
            starts++;
            last_start = cyc;
         end else begin
            j++;
         end
         case (stub_mode)
            0: begin
               ula_finish = (j >= 10);
               ula_dout   = (j >= 10) ? 28'h0ABCDEF : 28'h0;
            end
            1: begin
               ula_finish = (j >= 10);
               ula_dout   = ula_multiplica ? ({4'h0, ula_a} * {4'h0, ula_b})
                                           : ({4'h0, ula_a} + {4'h0, ula_b});
            end
            2: begin
               ula_finish = 1'b0;
               ula_dout   = 28'h0FFFFFF;
            end
            default: begin
               ula_finish = (j <= 1) || (j >= 5);
               ula_dout   = (j <= 1) ? 28'h0DEAD00 : 28'h0123456;
            end
         endcase
      end
   end

   // Monitor: pops the scoreboard on every done pulse
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (chk_ocup) begin
            chk("ocupado_after_done", ocupado, 0);
            chk_ocup = 1'b0;
         end
         if (req0_ready && req1_ready) begin
            tests++;
            fails++;
            $display("FAIL ready_both: got 11 expected at most one");
         end
         if (req0_done || req1_done) begin
            dones++;
            chk_ocup = 1'b1;
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_done: got done=%b%b expected none", req1_done, req0_done);
            end else begin
               e = sb.pop_front();
               chk("done_id", {req1_done, req0_done}, e.id ? 2'b10 : 2'b01);
               chk("dout", e.id ? req1_dout : req0_dout, e.dout);
               chk("erro", e.id ? req1_erro : req0_erro, e.erro);
               chk("latency", cyc - last_start, e.lat);
               if (e.id) begin
                  chk("hold_other", {req0_erro, req0_dout}, {sh0_erro, sh0_dout});
                  sh1_dout = e.dout;
                  sh1_erro = e.erro;
               end else begin
                  chk("hold_other", {req1_erro, req1_dout}, {sh1_erro, sh1_dout});
                  sh0_dout = e.dout;
                  sh0_erro = e.erro;
               end
            end
         end
      end
   end

   task automatic push(input logic id, input logic [27:0] d, input logic er, input int lat);
      exp_t e;
      e.id = id; e.dout = d; e.erro = er; e.lat = lat;
      sb.push_back(e);
   endtask

   task automatic drive(input int n, input logic [23:0] a, input logic [23:0] b, input logic m);
      logic ok;
      ok = 1'b0;
      @(negedge clk);
      if (n == 0) begin
         req0_a = a; req0_b = b; req0_mult = m; req0_valid = 1'b1;
      end else begin
         req1_a = a; req1_b = b; req1_mult = m; req1_valid = 1'b1;
      end
      for (int k = 0; k < 300 && !ok; k++) begin
         #1;
         if ((n == 0) ? req0_ready : req1_ready) begin
            ok = 1'b1;
            @(posedge clk);
            #1;
         end else begin
            @(negedge clk);
         end
      end
      if (n == 0) req0_valid = 1'b0;
      else        req1_valid = 1'b0;
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout: requester %0d not accepted", n);
      end
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (sb.size() != 0 && k < 400) begin
         @(negedge clk);
         k++;
      end
      if (sb.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
         sb.delete();
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      sh0_dout = '0; sh1_dout = '0; sh0_erro = 1'b0; sh1_erro = 1'b0;
   endtask

   function automatic logic [127:0] all_outs();
      return {req0_ready, req1_ready, req0_done, req1_done, req0_erro, req1_erro,
              req0_dout, req1_dout, ula_a, ula_b, ula_multiplica, ula_start, ocupado};
   endfunction

   initial begin
      int s0;
      int d0;
      int k;
      reset = 1'b1;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_mult = 1'b0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_mult = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", all_outs(), '0);
      reset = 1'b0;

      // single add on req0, fixed stub result
      stub_mode = 0;
      push(1'b0, 28'h0ABCDEF, 1'b0, 11);
      drive(0, 24'h000123, 24'h000456, 1'b0);
      drain();

      // both valid together right after reset: req0 first
      pulse_reset();
      stub_mode = 1;
      s0 = starts;
      push(1'b0, 28'h0000030, 1'b0, 11);
      push(1'b1, 28'h0000101, 1'b0, 11);
      fork
         drive(0, 24'h000010, 24'h000020, 1'b0);
         drive(1, 24'h000100, 24'h000001, 1'b0);
      join
      drain();
      chk("start_pulses_two", starts - s0, 2);

      // both held valid across four ops: grants 0,1,0,1
      pulse_reset();
      push(1'b0, 28'h0000030, 1'b0, 11);
      push(1'b1, 28'h0000101, 1'b0, 11);
      push(1'b0, 28'd15, 1'b0, 11);
      push(1'b1, 28'd42, 1'b0, 11);
      fork
         begin
            drive(0, 24'h000010, 24'h000020, 1'b0);
            drive(0, 24'd3, 24'd5, 1'b1);
         end
         begin
            drive(1, 24'h000100, 24'h000001, 1'b0);
            drive(1, 24'd7, 24'd6, 1'b1);
         end
      join
      drain();

      // ALU never finishes: timeout abort on req1
      stub_mode = 2;
      push(1'b1, 28'h0, 1'b1, TO + 1);
      drive(1, 24'd9, 24'd9, 1'b1);
      drain();

      // stale finish during the first wait cycle, real finish at start+5
      stub_mode = 3;
      push(1'b0, 28'h0123456, 1'b0, 6);
      drive(0, 24'd1, 24'd2, 1'b0);
      drain();

      // reset while waiting on the ALU abandons the op
      stub_mode = 0;
      s0 = starts;
      d0 = dones;
      drive(1, 24'd4, 24'd4, 1'b0);
      k = 0;
      while (starts == s0 && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("reset_op_started", starts - s0, 1);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("reset_mid_op_outputs", all_outs(), '0);
      reset = 1'b0;
      sh0_dout = '0; sh1_dout = '0; sh0_erro = 1'b0; sh1_erro = 1'b0;
      repeat (15) @(negedge clk);
      chk("no_done_after_reset", dones - d0, 0);

      push(1'b0, 28'h0ABCDEF, 1'b0, 11);
      drive(0, 24'd8, 24'd8, 1'b0);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/arbitro_ulauc.md
ARBITRO_ULAUC -- requirements
Module: arbitro_ulauc

Interface
REQ-001 Parameter TIMEOUT, default 80, max cycles in AGUARDA before ERRO abort (>= 56, covers 24-bit multiply).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 reqN_valid  in  1  (N=0,1) requester N has an operation pending.
REQ-005 reqN_ready  out  1  accept strobe; transfer when reqN_valid and reqN_ready both high.
REQ-006 reqN_a, reqN_b  in  24  mantissa operands.
REQ-007 reqN_mult  in  1  1 = multiply, 0 = add.
REQ-008 reqN_done  out  1  one-cycle pulse; result for requester N valid.
REQ-009 reqN_dout  out  28  result register, held until next reqN_done.
REQ-010 reqN_erro  out  1  qualifies reqN_done; 1 = timeout abort.
REQ-011 ula_a, ula_b  out  24  operands driven to the mantissa ALU.
REQ-012 ula_multiplica  out  1  operation select to the ALU.
REQ-013 ula_start  out  1  one-cycle start pulse to the ALU.
REQ-014 ula_finish  in  1  ALU completion level.
REQ-015 ula_dout  in  28  ALU result.
REQ-016 ocupado  out  1  high in every state except OCIOSO.

Function
REQ-017 FSM states SHALL be OCIOSO, DISPARA, AGUARDA, ENTREGA.
REQ-018 In OCIOSO, reqN_ready SHALL be combinationally high only for the arbitration winner among valid requesters; both low if none valid.
REQ-019 Single valid requester SHALL win; both valid -> winner is the one indicated by prio.
REQ-020 On accept: latch a, b, mult and granted id into internal registers, toggle prio to the non-granted requester, go to DISPARA.
REQ-021 DISPARA: ula_start = 1 for exactly one cycle, counter cleared, next AGUARDA.
REQ-022 ula_a, ula_b, ula_multiplica SHALL equal latched operands from DISPARA through ENTREGA; ula_start low in every other state.
REQ-023 AGUARDA: ula_finish ignored during first AGUARDA cycle (stale finish from previous op); counter increments each cycle.
REQ-024 AGUARDA: ula_finish high (after blanking) -> capture ula_dout into granted reqN_dout, erro = 0, go ENTREGA.
REQ-025 AGUARDA: counter reaches TIMEOUT-1 without finish -> reqN_dout = 0, erro = 1, go ENTREGA; finish and timeout in same cycle -> finish wins.
REQ-026 ENTREGA: granted reqN_done = 1 for one cycle, reqN_erro valid same cycle, next OCIOSO; no new accept in ENTREGA.
REQ-027 Latency: accept cycle T, ula_start at T+1, done at F+1 where F is first qualifying finish cycle; minimum T+4.
REQ-028 reqN_valid dropping while not granted SHALL have no effect; after accept, request inputs are don't-care until done.
REQ-029 Non-granted reqN_dout/reqN_erro SHALL hold their previous values.

Reset
REQ-030 Reset SHALL force OCIOSO, prio = 0, counter = 0, all outputs 0 (ready, done, erro, dout, ula_*, ocupado) at the next edge.
REQ-031 Reset mid-operation SHALL abandon the op with no reqN_done; the ALU is not otherwise notified.

Structure
REQ-032 Shared package SHALL hold state encoding, mantissa width 24, result width 28, TIMEOUT default.
REQ-033 Single flat module; no sub-module required.

Verification
REQ-034 Stub ALU asserts finish 10 cycles after start with ula_dout = 28'h0ABCDEF; req0 add -> req0_done at start+11, req0_dout = 28'h0ABCDEF, erro = 0.
REQ-035 req0 and req1 valid in same cycle after reset -> req0 served first, req1 next, ula_start pulses exactly twice.
REQ-036 Both held valid for 4 ops -> grants alternate 0,1,0,1.
REQ-037 Stub never finishes -> done at start+TIMEOUT+1 with erro = 1, dout = 0; ocupado clears next cycle.
REQ-038 Stub finish stuck high from prior op, then real finish at start+5 -> blanking prevents capture before start+2.
REQ-039 Reset asserted in AGUARDA -> no done, all outputs 0, next request accepted normally.
